// File: rtl/fnd_value_counter.sv
// ---------------------------------------------------------------------------
// fnd_value_counter
//
// Four-digit (0..9999) up/down counter for an FND display, driven by three
// push buttons. Each raw button is synchronized, debounced and turned into a
// single-cycle press pulse. A STOP/RUN state machine gates a prescaler that
// produces one count step every TICK_DIV clock cycles.
//
// Parameters
//   TICK_DIV   clock cycles per count step (2..2^26)
//   DB_CYCLES  consecutive stable cycles before a debounced level changes
//              (2..2^24)
//
// Ports
//   i_clk         system clock, rising-edge
//   i_reset       asynchronous, active-high reset
//   i_btnRunStop  raw button, toggles STOP/RUN on press
//   i_btnClear    raw button, zeroes the count and the prescaler on press
//   i_btnMode     raw button, toggles the count direction on press
//   o_value       registered count, always 0..9999
//   o_running     the FSM state register itself: 1 = RUN, 0 = STOP
//   o_modeDown    registered direction: 0 = up, 1 = down
//
// Handshake: none. Button pulses are fire-and-forget one-cycle strobes that
// the counter always consumes on the cycle they are high.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// fnd_value_counter_debounce
//
// Two-flop synchronizer, stability-counter debouncer and press detector for
// one button.
//
// Ports
//   clk    system clock
//   rst    asynchronous, active-high reset
//   btn    raw asynchronous button level
//   pulse  one-cycle strobe, high on the cycle after the debounced level
//          rises; releases produce nothing
// ---------------------------------------------------------------------------
module fnd_value_counter_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync_meta;
    logic          sync_out;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
            level     <= 1'b0;
            cnt       <= '0;
            pulse     <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_out  <= sync_meta;
            pulse     <= 1'b0;
            if (sync_out == level) begin
                // Any agreeing cycle restarts the stability window.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // This is the DB_CYCLES-th disagreeing cycle in a row: accept
                // the new level. The pulse register loads together with the
                // level, so the strobe is visible in the cycle after the
                // level change and is consumed on the following edge.
                level <= sync_out;
                cnt   <= '0;
                pulse <= sync_out;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

module fnd_value_counter #(
    parameter int TICK_DIV  = 10_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_btnRunStop,
    input  logic        i_btnClear,
    input  logic        i_btnMode,
    output logic [13:0] o_value,
    output logic        o_running,
    output logic        o_modeDown
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0]   VALUE_MAX  = 14'd9999;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_next;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_next;
    logic [13:0]   value_next;
    logic          mode_next;
    logic          tick;

    logic          runstop_pulse;
    logic          clear_pulse;
    logic          mode_pulse;

    // -----------------------------------------------------------------------
    // Button front ends
    // -----------------------------------------------------------------------
    fnd_value_counter_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_runstop (
        .clk   (i_clk),
        .rst   (i_reset),
        .btn   (i_btnRunStop),
        .pulse (runstop_pulse)
    );

    fnd_value_counter_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_clear (
        .clk   (i_clk),
        .rst   (i_reset),
        .btn   (i_btnClear),
        .pulse (clear_pulse)
    );

    fnd_value_counter_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_mode (
        .clk   (i_clk),
        .rst   (i_reset),
        .btn   (i_btnMode),
        .pulse (mode_pulse)
    );

    // -----------------------------------------------------------------------
    // State, prescaler, count and direction registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= STOP;
            presc_q    <= '0;
            o_value    <= '0;
            o_modeDown <= 1'b0;
        end else begin
            state_q    <= state_next;
            presc_q    <= presc_next;
            o_value    <= value_next;
            o_modeDown <= mode_next;
        end
    end

    // The state register is one bit with RUN encoded as 1, so this is a
    // plain view of a flop rather than logic on any input.
    assign o_running = (state_q == RUN);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_q;
        presc_next = presc_q;
        value_next = o_value;
        mode_next  = o_modeDown;
        tick       = 1'b0;

        case (state_q)
            STOP: begin
                // Prescaler is frozen while stopped; a restart begins a full
                // TICK_DIV period.
                if (runstop_pulse) begin
                    state_next = RUN;
                    presc_next = '0;
                end
            end
            RUN: begin
                tick = (presc_q == PRESC_LAST);
                // The stopping cycle still advances the prescaler and applies
                // any coincident tick; the new state freezes it afterwards.
                presc_next = tick ? '0 : presc_q + PW'(1);
                if (runstop_pulse) begin
                    state_next = STOP;
                end
            end
            default: begin
                state_next = STOP;
            end
        endcase

        // The tick uses the direction held before any coincident Mode press.
        if (tick) begin
            if (o_modeDown) begin
                value_next = (o_value == 14'd0) ? VALUE_MAX : o_value - 14'd1;
            end else begin
                value_next = (o_value >= VALUE_MAX) ? 14'd0 : o_value + 14'd1;
            end
        end

        if (mode_pulse) begin
            mode_next = ~o_modeDown;
        end

        // Clear wins over a coincident tick and leaves state and direction
        // alone.
        if (clear_pulse) begin
            value_next = '0;
            presc_next = '0;
        end
    end

endmodule

// File: tb/tb_fnd_value_counter.sv
module tb_fnd_value_counter;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int HL = DB + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        b_rs = 1'b0;
  logic        b_clr = 1'b0;
  logic        b_md = 1'b0;
  logic [13:0] value;
  logic        running;
  logic        mode_down;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  fnd_value_counter #(
    .TICK_DIV  (TD),
    .DB_CYCLES (DB)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_btnRunStop (b_rs),
    .i_btnClear   (b_clr),
    .i_btnMode    (b_md),
    .o_value      (value),
    .o_running    (running),
    .o_modeDown   (mode_down)
  );

  // ---------------- reference model ----------------
  // Buttons: 0 = run/stop, 1 = clear, 2 = mode.
  // m_hist[b][0] is the raw level seen at this edge; the logic acts on the
  // level seen two edges earlier. A debounced level flips once the last DB
  // acted-on samples all disagree with it. A press event is acted on one
  // edge after its level rises.
  bit m_hist[3][HL];
  bit m_level[3];
  bit m_rise[3];
  bit m_run;
  bit m_down;
  int m_value;
  int m_phase;

  always @(posedge clk or posedge rst) begin : model
    bit ev[3];
    bit raw[3];
    bit tick;
    bit all_diff;
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        for (int i = 0; i < HL; i++) m_hist[b][i] = 1'b0;
        m_level[b] = 1'b0;
        m_rise[b] = 1'b0;
      end
      m_run = 1'b0;
      m_down = 1'b0;
      m_value = 0;
      m_phase = 0;
    end else begin
      for (int b = 0; b < 3; b++) ev[b] = m_rise[b];
      tick = m_run && (m_phase == TD - 1);
      if (ev[1]) begin
        m_value = 0;
        m_phase = 0;
      end else begin
        if (tick) m_value = m_down ? (m_value + 9999) % 10000 : (m_value + 1) % 10000;
        if (m_run) m_phase = (m_phase + 1) % TD;
        else if (ev[0]) m_phase = 0;
      end
      if (ev[0]) m_run = !m_run;
      if (ev[2]) m_down = !m_down;

      raw[0] = b_rs;
      raw[1] = b_clr;
      raw[2] = b_md;
      for (int b = 0; b < 3; b++) begin
        for (int i = HL - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
        m_hist[b][0] = raw[b];
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) if (m_hist[b][2+j] == m_level[b]) all_diff = 1'b0;
        m_rise[b] = 1'b0;
        if (all_diff) begin
          m_level[b] = !m_level[b];
          m_rise[b] = m_level[b];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    b_rs = 1'b0;
    b_clr = 1'b0;
    b_md = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_run();
    b_rs = 1'b1;
    repeat (8) @(negedge clk);
    b_rs = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (value !== 14'd0) begin miscompares++; $display("FAIL reset_value: got %0d expected 0", value); end
    vectors++;
    if (running !== 1'b0) begin miscompares++; $display("FAIL reset_running: got %b expected 0", running); end
    vectors++;
    if (mode_down !== 1'b0) begin miscompares++; $display("FAIL reset_mode: got %b expected 0", mode_down); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_runstop_hold();
    int first;
    do_reset();
    first = -1;
    b_rs = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (running === 1'b1 && first < 0) first = i;
    end
    vectors++;
    if (first != 6) begin miscompares++; $display("FAIL hold_latency: got %0d expected 6", first); end
    vectors++;
    if (value !== 14'd1) begin miscompares++; $display("FAIL hold_first_step: got %0d expected 1", value); end
    b_rs = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (value !== 14'd2) begin miscompares++; $display("FAIL hold_second_step: got %0d expected 2", value); end
    repeat (20) @(negedge clk);
    vectors++;
    if (running !== 1'b1) begin miscompares++; $display("FAIL release_no_pulse: got %b expected 1", running); end
    vectors++;
    if (value !== 14'd7) begin miscompares++; $display("FAIL release_count: got %0d expected 7", value); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      b_rs = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
      @(negedge clk);
      vectors++;
      if (running !== 1'b0 || running !== m_run) begin
        miscompares++;
        $display("FAIL bounce_running cycle %0d: got %b expected 0", i, running);
      end
    end
  endtask

  task automatic test_clear_tick();
    int n;
    do_reset();
    start_run();
    n = 0;
    while (!(m_value == 56 && m_phase == 2) && n < 2000) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 2000) begin miscompares++; $display("FAIL clear_align: got timeout expected value 56"); end
    b_clr = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (value !== 14'd57) begin miscompares++; $display("FAIL clear_pre: got %0d expected 57", value); end
    repeat (4) @(negedge clk);
    vectors++;
    if (value !== 14'd0) begin miscompares++; $display("FAIL clear_over_tick: got %0d expected 0", value); end
    vectors++;
    if (running !== 1'b1) begin miscompares++; $display("FAIL clear_keeps_run: got %b expected 1", running); end
    repeat (3) @(negedge clk);
    vectors++;
    if (value !== 14'd0) begin miscompares++; $display("FAIL clear_hold3: got %0d expected 0", value); end
    @(negedge clk);
    vectors++;
    if (value !== 14'd1) begin miscompares++; $display("FAIL clear_next_step: got %0d expected 1", value); end
    b_clr = 1'b0;
  endtask

  task automatic test_pause_resume();
    int n;
    do_reset();
    start_run();
    n = 0;
    while (!(m_value == 10 && m_phase == 3) && n < 500) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 500) begin miscompares++; $display("FAIL pause_align: got timeout expected value 10"); end
    b_rs = 1'b1;
    @(negedge clk);
    vectors++;
    if (value !== 14'd11) begin miscompares++; $display("FAIL pause_pre: got %0d expected 11", value); end
    repeat (5) @(negedge clk);
    vectors++;
    if (running !== 1'b0) begin miscompares++; $display("FAIL pause_stop: got %b expected 0", running); end
    b_rs = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      vectors++;
      if (value !== 14'd12 || running !== 1'b0) begin
        miscompares++;
        $display("FAIL pause_hold cycle %0d: got value %0d run %b expected 12 run 0", i, value, running);
      end
    end
    b_rs = 1'b1;
    repeat (6) @(negedge clk);
    vectors++;
    if (running !== 1'b1 || value !== 14'd12) begin
      miscompares++;
      $display("FAIL resume_start: got run %b value %0d expected run 1 value 12", running, value);
    end
    b_rs = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (value !== 14'd13) begin miscompares++; $display("FAIL resume_step: got %0d expected 13", value); end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    start_run();
    n = 0;
    while (!(m_value == 9998 && m_phase == 2) && n < 45000) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 45000) begin miscompares++; $display("FAIL wrap_align: got timeout expected value 9998"); end
    b_md = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (value !== 14'd9999) begin miscompares++; $display("FAIL wrap_max: got %0d expected 9999", value); end
    repeat (4) @(negedge clk);
    vectors++;
    if (value !== 14'd0) begin miscompares++; $display("FAIL wrap_up_to_zero: got %0d expected 0", value); end
    vectors++;
    if (mode_down !== 1'b1) begin miscompares++; $display("FAIL wrap_mode: got %b expected 1", mode_down); end
    b_md = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (value !== 14'd9999) begin miscompares++; $display("FAIL wrap_down_to_max: got %0d expected 9999", value); end
  endtask

  task automatic test_async_reset();
    int n;
    int first;
    do_reset();
    start_run();
    n = 0;
    while (m_value != 300 && n < 2000) begin @(negedge clk); n++; end
    b_md = 1'b1;
    repeat (8) @(negedge clk);
    b_md = 1'b0;
    n = 0;
    while (!(m_down && m_value == 300) && n < 200) begin @(negedge clk); n++; end
    vectors++;
    if (value !== 14'd300 || mode_down !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre: got value %0d down %b expected 300 down 1", value, mode_down);
    end
    #2;
    rst = 1'b1;
    b_rs = 1'b1;
    #1;
    vectors++;
    if (value !== 14'd0 || running !== 1'b0 || mode_down !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_immediate: got value %0d run %b down %b expected all 0", value, running, mode_down);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (running === 1'b1 && first < 0) first = i;
    end
    vectors++;
    if (first != 6) begin miscompares++; $display("FAIL areset_held_button: got %0d expected 6", first); end
    b_rs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    int rem[3];
    bit lvl[3];
    do_reset();
    for (int b = 0; b < 3; b++) begin rem[b] = 0; lvl[b] = 1'b0; end
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = ($urandom_range(0, 2) == 0);
          rem[b] = $urandom_range(1, 12);
        end
        rem[b]--;
      end
      b_rs = lvl[0];
      b_clr = lvl[1];
      b_md = lvl[2];
      rst = ($urandom_range(0, 999) == 0);
      @(negedge clk);
      vectors++;
      if (value !== 14'(m_value) || running !== m_run || mode_down !== m_down) begin
        miscompares++;
        $display("FAIL random cycle %0d: got value %0d run %b down %b expected value %0d run %b down %b",
                 c, value, running, mode_down, m_value, m_run, m_down);
      end
    end
    rst = 1'b0;
    b_rs = 1'b0;
    b_clr = 1'b0;
    b_md = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_runstop_hold();
    test_bounce();
    test_clear_tick();
    test_pause_resume();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
